// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch front end for the 5-stage mips32 pipeline. Issues
//   word-addressed requests to a handshaked instruction memory (at most one
//   outstanding), buffers the returned words in a DEPTH-entry FIFO and presents
//   {IR, NPC} pairs to decode through a registered output stage with a
//   valid/ready handshake. A redirect from execute flushes everything and
//   squashes any in-flight fetch.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   redirect/_pc         taken branch from execute and its word target
//   imem_req/_addr       fetch request, held with a stable address until gnt
//   imem_gnt             request accepted this cycle
//   imem_rvalid/_rdata   in-order read response, >=1 cycle after its grant
//   ir_valid/_ready      head-of-queue handshake towards decode
//   ir_data/_npc         head instruction and its address + 1 (mod 2^AW)
//
// Optional feature macro: IFQ_HALT_DETECT_EN
//   When defined, pushing a word whose opcode field is 6'b111111 parks the
//   fetch FSM in HALTED (no further requests) until the next redirect.
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int DEPTH    = 4,
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [DW-1:0] ir_data,
    output logic [AW-1:0] ir_npc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef IFQ_HALT_DETECT_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;
`endif

    state_t         state_q;
    logic [AW-1:0]  pc_q;
    logic           req_q;

    logic [DW+AW-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic [CW-1:0]  total_d;

    logic           irv_q, irv_d;
    logic [DW-1:0]  ird_q;
    logic [AW-1:0]  irn_q;

    logic gnt_ok, push, pop, load, credit_ok;

    // gnt only means something while a request is actually presented
    assign gnt_ok = req_q & imem_gnt;

    // Responses are only accepted in WAIT; in DROP (or after a reset with no
    // grant since) they are silently discarded.
    assign push = (state_q == S_WAIT) & imem_rvalid & ~redirect;
    assign pop  = irv_q & ir_ready & ~redirect;

    // The output register refills from the FIFO when empty or being popped.
    // A push only lands in the FIFO, so a fresh word reaches ir_valid one edge
    // after it is written (no bypass).
    assign load = (fcnt_q != '0) & (~irv_q | pop) & ~redirect;

    assign fcnt_d  = redirect ? '0 : fcnt_q + CW'(push) - CW'(load);
    assign irv_d   = redirect ? 1'b0 : (load | (irv_q & ~pop));

    // Credit covers FIFO plus output register: a request is only issued while
    // a free slot exists, so the single outstanding response can never overflow.
    assign total_d   = fcnt_d + CW'(irv_d);
    assign credit_ok = total_d < CW'(DEPTH);

`ifdef IFQ_HALT_DETECT_EN
    logic halt_word;
    assign halt_word = (imem_rdata[DW-1 -: 6] == 6'b111111);
`endif

    // Fetch FSM; imem_req is registered and re-evaluated on every entry to /
    // stay in REQ against the next-cycle queue occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= AW'(RESET_PC);
            req_q   <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (redirect)
                pc_q <= redirect_pc;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= credit_ok;
                end
                S_REQ: begin
                    if (redirect) begin
                        // granted-and-redirected fetch is still owed a response
                        if (gnt_ok) state_q <= S_DROP;
                        else        req_q   <= credit_ok;
                    end else if (gnt_ok) begin
                        state_q <= S_WAIT;
                        pc_q    <= pc_q + AW'(1);
                    end else begin
                        req_q <= credit_ok;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
`ifdef IFQ_HALT_DETECT_EN
                        if (halt_word && !redirect) begin
                            state_q <= S_HALT;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= credit_ok;
                        end
`else
                        state_q <= S_REQ;
                        req_q   <= credit_ok;
`endif
                    end else if (redirect) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                        req_q   <= credit_ok;
                    end
                end
`ifdef IFQ_HALT_DETECT_EN
                S_HALT: begin
                    if (redirect) begin
                        state_q <= S_REQ;
                        req_q   <= credit_ok;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Queue control and output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            irv_q  <= 1'b0;
            ird_q  <= '0;
            irn_q  <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            irv_q  <= irv_d;
            if (redirect) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (load) rptr_q <= rptr_q + PW'(1);
            end
            // data/npc only change on a load, so they hold while ir_valid=0
            if (load)
                {ird_q, irn_q} <= mem_q[rptr_q];
        end
    end

    // Storage: pc_q already points at addr+1 while waiting for the response.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= {imem_rdata, pc_q};
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir_valid  = irv_q;
    assign ir_data   = ird_q;
    assign ir_npc    = irn_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, redirect, imem_req, imem_gnt, imem_rvalid, ir_valid, ir_ready;
  logic [AW-1:0] redirect_pc, imem_addr, ir_npc;
  logic [DW-1:0] imem_rdata, ir_data;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_npc(ir_npc)
  );

  typedef struct { logic [DW-1:0] data; logic [AW-1:0] npc; } exp_t;
  typedef struct { int tgt; int a0; int a1; int npc_last; } vec_t;

  exp_t sb[$];
  logic [AW-1:0] gnt_log[$];
  int tests = 0, fails = 0;
  int budget = 0, rv_lat = 1, rv_cnt = 0, halt_addr = 2000;
  logic [AW-1:0] pend_addr = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (int'(a) == halt_addr) return 32'hFC00_0000;
    return 32'h2400_0000 | {22'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int a);
    exp_t e;
    e.data = mem_word(AW'(a));
    e.npc  = AW'(a + 1);
    sb.push_back(e);
  endtask

  task automatic do_redirect(input int pc);
    redirect = 1'b1;
    redirect_pc = AW'(pc);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check({name, "_drain_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_grants(input string name, input int n);
    for (int i = 0; i < 50; i++) begin
      if (gnt_log.size() >= n) break;
      @(posedge clk); #1;
    end
    check({name, "_grant_seen"}, 32'(gnt_log.size() >= n), 32'd1);
  endtask

  // Memory responder: grants while budget remains, answers rv_lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
      imem_gnt = 1'b0;
      if (imem_req && budget > 0) begin
        imem_gnt = 1'b1;
        budget--;
        pend_addr = imem_addr;
        rv_cnt = rv_lat;
        gnt_log.push_back(imem_addr);
      end
    end
  end

  // Decode-side monitor: each accepted head is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ir_valid && ir_ready && !redirect) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pop: got npc 0x%0h data 0x%0h, none expected", ir_npc, ir_data);
        end else begin
          e = sb.pop_front();
          check("pop_data", ir_data, e.data);
          check("pop_npc", 32'(ir_npc), 32'(e.npc));
        end
      end
    end
  end

  initial begin
    vec_t vecs[4];
    int base;
    vecs[0] = '{1023, 1023, 0, 1};
    vecs[1] = '{100, 100, 101, 102};
    vecs[2] = '{511, 511, 512, 513};
    vecs[3] = '{1022, 1022, 1023, 0};

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; ir_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_data", ir_data, 32'd0);
    check("rst_npc", 32'(ir_npc), 32'd0);
    rst = 1'b0;

    // sequential fetch, decode always ready
    budget = 4;
    for (int a = 0; a < 4; a++) expect_word(a);
    wait_drain("t1");
    for (int a = 0; a < 4; a++) check("t1_addr", 32'(gnt_log[a]), 32'(a));
    check("t1_req_next", 32'(imem_req), 32'd1);
    check("t1_addr_next", 32'(imem_addr), 32'd4);

    // decode stalled: credit stops requests after DEPTH words
    ir_ready = 1'b0; budget = 100; base = gnt_log.size();
    for (int a = 4; a < 8; a++) expect_word(a);
    repeat (20) @(posedge clk); #1;
    check("t2_grants", 32'(gnt_log.size() - base), 32'd4);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_head_npc", 32'(ir_npc), 32'd5);
    expect_word(8);
    ir_ready = 1'b1;
    @(posedge clk); #1;
    ir_ready = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("t2_grants_after_pop", 32'(gnt_log.size() - base), 32'd5);
    check("t2_new_addr", 32'(gnt_log[base + 4]), 32'd8);
    check("t2_req_off2", 32'(imem_req), 32'd0);
    budget = 0;
    // redirect with a coincident pop: flush, pop ignored
    sb.delete();
    ir_ready = 1'b1;
    do_redirect(5);
    check("t2_flush_valid", 32'(ir_valid), 32'd0);
    check("t2_redir_req", 32'(imem_req), 32'd1);
    check("t2_redir_addr", 32'(imem_addr), 32'd5);

    // redirect while waiting for the response of address 5
    rv_lat = 3; budget = 1; base = gnt_log.size();
    wait_grants("t3", base + 1);
    do_redirect(32);
    check("t3_drop_valid", 32'(ir_valid), 32'd0);
    check("t3_drop_req", 32'(imem_req), 32'd0);
    rv_lat = 1; budget = 2;
    expect_word(32); expect_word(33);
    wait_drain("t3");
    check("t3_addr0", 32'(gnt_log[base]), 32'd5);
    check("t3_addr1", 32'(gnt_log[base + 1]), 32'd32);
    check("t3_addr2", 32'(gnt_log[base + 2]), 32'd33);

    // redirect in the same cycle as the grant of address 7
    do_redirect(7);
    base = gnt_log.size();
    budget = 1;
    do_redirect(16);
    check("t4_drop_req", 32'(imem_req), 32'd0);
    budget = 1;
    expect_word(16);
    wait_drain("t4");
    check("t4_squashed", 32'(gnt_log[base]), 32'd7);
    check("t4_target", 32'(gnt_log[base + 1]), 32'd16);

    // table of redirect targets, including PC wrap, with latency checks
    for (int i = 0; i < 4; i++) begin
      do_redirect(vecs[i].tgt);
      base = gnt_log.size();
      budget = 2;
      expect_word(vecs[i].a0); expect_word(vecs[i].a1);
      for (int k = 0; k < 20; k++) begin
        if (imem_rvalid) break;
        @(posedge clk); #1;
      end
      check("v_rvalid_seen", 32'(imem_rvalid), 32'd1);
      check("v_lat_edge_n", 32'(ir_valid), 32'd0);
      @(posedge clk); #1;
      check("v_lat_edge_n1", 32'(ir_valid), 32'd1);
      wait_drain("v");
      check("v_addr0", 32'(gnt_log[base]), 32'(vecs[i].a0));
      check("v_addr1", 32'(gnt_log[base + 1]), 32'(vecs[i].a1));
      check("v_hold_npc", 32'(ir_npc), 32'(vecs[i].npc_last));
      check("v_hold_data", ir_data, mem_word(AW'(vecs[i].a1)));
      check("v_idle_valid", 32'(ir_valid), 32'd0);
    end

    // halt word at address 2
    halt_addr = 2;
`ifdef IFQ_HALT_DETECT_EN
    do_redirect(0);
    base = gnt_log.size();
    budget = 10;
    for (int a = 0; a < 3; a++) expect_word(a);
    repeat (20) @(posedge clk); #1;
    wait_drain("t6");
    check("t6_grants", 32'(gnt_log.size() - base), 32'd3);
    check("t6_halted_req", 32'(imem_req), 32'd0);
    budget = 0;
    halt_addr = 2000;
    do_redirect(0);
    budget = 1;
    expect_word(0);
    wait_drain("t6_resume");
    check("t6_resume_addr", 32'(gnt_log[base + 3]), 32'd0);
`else
    do_redirect(0);
    base = gnt_log.size();
    budget = 4;
    for (int a = 0; a < 4; a++) expect_word(a);
    wait_drain("t6");
    for (int a = 0; a < 4; a++) check("t6_addr", 32'(gnt_log[base + a]), 32'(a));
    check("t6_req_on", 32'(imem_req), 32'd1);
    halt_addr = 2000;
`endif

    // reset in the middle of a fetch, stale response must be ignored
    do_redirect(48);
    ir_ready = 1'b0; rv_lat = 1; budget = 1; base = gnt_log.size();
    expect_word(48);
    wait_grants("t7a", base + 1);
    repeat (4) @(posedge clk); #1;
    rv_lat = 4; budget = 1;
    wait_grants("t7b", base + 2);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(ir_valid), 32'd0);
    check("t7_rst_addr", 32'(imem_addr), 32'd0);
    check("t7_rst_req", 32'(imem_req), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ir_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("t7_stale_valid", 32'(ir_valid), 32'd0);
    check("t7_req_addr", 32'(imem_addr), 32'd0);
    check("t7_req_on", 32'(imem_req), 32'd1);
    rv_lat = 1; budget = 1;
    expect_word(0);
    wait_drain("t7");
    check("t7_first_addr", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
